mips_harvard_cpu: RTL and testbench
===================================

# mips_harvard_cpu

Multicycle 32-bit MIPS-I subset processor with separate instruction and data buses (Harvard). It executes from an external synchronous-read instruction ROM and uses an external synchronous data RAM. It runs from the reset vector until control transfers to address 0, then halts and deasserts `active`. `register_v0`, `check_state` and `check_pcout` are debug outputs for the test environment.

## Interface
Parameters: none.
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- active  out  1  1 while executing; 0 once halted
- register_v0  out  32  live copy of GPR $2
- clk_enable  in  1  1 = advance; 0 = freeze all state (no writes, no state change)
- instr_address  out  32  byte address of instruction fetch (= PC)
- instr_readdata  in  32  instruction word, valid the cycle after address is presented
- data_address  out  32  byte address for load/store (word aligned)
- data_write  out  1  store strobe, one cycle
- data_read  out  1  load strobe, one cycle
- data_writedata  out  32  store data (rt)
- data_readdata  in  32  load data, valid the cycle after data_read
- check_state  out  2  current FSM state encoding
- check_pcout  out  32  current PC

## Operation
- Reset (reset=0, async): PC=0xBFC00000, state=FETCH, active=1, all 32 GPRs=0, delay-slot target cleared, data_read=data_write=0.
- FSM (check_state): FETCH=0, EXEC=1, MEM=2, HALT=3.
  - FETCH: instr_address=PC → EXEC.
  - EXEC: decode instr_readdata, compute ALU/branch; ALU results written to GPR; LW asserts data_read → MEM; SW asserts data_write → FETCH; others → FETCH.
  - MEM: write data_readdata to rt → FETCH.
  - Entering FETCH with next PC == 0 → HALT instead; HALT: active=0, no bus strobes, stays until reset.
- Instructions: ADDU, SUBU, AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA, JR, JALR, ADDIU, ANDI, ORI, XORI, SLTI, SLTIU, LUI, LW, SW, BEQ, BNE, J, JAL. Unrecognised opcodes execute as NOP.
- Arithmetic modulo 2^32, no overflow traps. ANDI/ORI/XORI zero-extend imm; ADDIU/SLTI/SLTIU/LW/SW/branches sign-extend.
- Branch offset = signext(imm)<<2 added to PC+4; J/JAL target = {PC+4[31:28], imm26, 2'b00}; JAL/JALR link = PC+8 into $31 / rd.
- Branch delay slot: the instruction after any taken branch/jump always executes; PC then loads the target.
- Writes to $0 discarded; $0 reads 0.
- data_address = rs + signext(imm); data_writedata = rt.
- register_v0 and check_pcout reflect register state combinationally.

## Timing
- FETCH→EXEC: 2 cycles for ALU/branch/store; 3 for LW.
- Strobes high only in the EXEC cycle; deasserted in all other states and during reset.
- clk_enable=0 on an edge: no register, PC or state change; outputs hold.
- Reset mid-instruction aborts it; no partial GPR write.
- active falls on the edge entering HALT.

## Test plan
- Reset then release → check_state=0, check_pcout=0xBFC00000, active=1 within 2 cycles; register_v0=0.
- ADDIU $2,$0,5; JR $0 with NOP delay slot → register_v0=0x00000005, then active=0, check_state=3.
- LUI $3,0x1234; ORI $3,$3,0x5678; SW $3,0($4); LW $2,0($4) → data_write then data_read pulse; register_v0=0x12345678.
- BEQ $0,$0,+2 with ADDIU $2,$2,1 in delay slot and ADDIU $2,$2,16 skipped → register_v0=1.
- JAL then JR $31 → $31=PC_jal+8, execution returns correctly.
- clk_enable held 0 for 5 cycles mid-program → PC, state, register_v0 unchanged; resumes identically.

Source files
------------

// File: rtl/mips_harvard_cpu.sv
// mips_harvard_cpu
//   Multicycle 32-bit MIPS-I subset core with separate instruction and data
//   buses. Each instruction takes FETCH -> EXEC (-> MEM for loads). Execution
//   starts at 0xBFC00000 and halts once control reaches address 0.
//
// Ports
//   clk, reset          clock, asynchronous active-low reset
//   clk_enable          1 = advance, 0 = hold every register
//   active              1 while running, 0 once halted
//   register_v0         live copy of GPR $2
//   instr_address       fetch address (= PC)
//   instr_readdata      instruction word, one cycle after the address
//   data_address        load/store byte address (rs + signext(imm))
//   data_write/read     one-cycle store/load strobes, only in EXEC
//   data_writedata      store data (rt)
//   data_readdata       load data, one cycle after data_read
//   check_state         FSM state (FETCH=0, EXEC=1, MEM=2, HALT=3)
//   check_pcout         current PC
module mips_harvard_cpu (
  input  logic        clk,
  input  logic        reset,
  output logic        active,
  output logic [31:0] register_v0,
  input  logic        clk_enable,
  output logic [31:0] instr_address,
  input  logic [31:0] instr_readdata,
  output logic [31:0] data_address,
  output logic        data_write,
  output logic        data_read,
  output logic [31:0] data_writedata,
  input  logic [31:0] data_readdata,
  output logic [1:0]  check_state,
  output logic [31:0] check_pcout
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_MEM   = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        active_q, active_d;
  logic        br_pending_q, br_pending_d;
  logic [31:0] br_target_q, br_target_d;
  logic [4:0]  load_rt_q, load_rt_d;
  logic [31:0] gpr_q [32];
  logic [31:0] gpr_d [32];

  // Instruction fields
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [31:0] imm_sext, imm_zext, rs_val, rt_val;
  logic [31:0] pc_plus4, pc_plus8, branch_dest;

  assign opcode   = instr_readdata[31:26];
  assign rs       = instr_readdata[25:21];
  assign rt       = instr_readdata[20:16];
  assign rd       = instr_readdata[15:11];
  assign shamt    = instr_readdata[10:6];
  assign funct    = instr_readdata[5:0];
  assign imm      = instr_readdata[15:0];
  assign imm_sext = {{16{imm[15]}}, imm};
  assign imm_zext = {16'h0000, imm};
  // $0 is never written, so reading the array directly yields 0 for it.
  assign rs_val   = gpr_q[rs];
  assign rt_val   = gpr_q[rt];
  assign pc_plus4 = pc_q + 32'd4;
  assign pc_plus8 = pc_q + 32'd8;
  assign branch_dest = pc_plus4 + {imm_sext[29:0], 2'b00};

  // Decode/ALU results
  logic        alu_wr, take_jump, is_lw, is_sw;
  logic [4:0]  alu_dst;
  logic [31:0] alu_result, jump_target;

  always_comb begin
    alu_wr      = 1'b0;
    alu_dst     = rd;
    alu_result  = '0;
    take_jump   = 1'b0;
    jump_target = '0;
    is_lw       = 1'b0;
    is_sw       = 1'b0;
    case (opcode)
      6'h00: begin
        alu_wr = 1'b1;
        case (funct)
          6'h21: alu_result = rs_val + rt_val;
          6'h23: alu_result = rs_val - rt_val;
          6'h24: alu_result = rs_val & rt_val;
          6'h25: alu_result = rs_val | rt_val;
          6'h26: alu_result = rs_val ^ rt_val;
          6'h2A: alu_result = {31'd0, $signed(rs_val) < $signed(rt_val)};
          6'h2B: alu_result = {31'd0, rs_val < rt_val};
          6'h00: alu_result = rt_val << shamt;
          6'h02: alu_result = rt_val >> shamt;
          6'h03: alu_result = $unsigned($signed(rt_val) >>> shamt);
          6'h08: begin
            alu_wr      = 1'b0;
            take_jump   = 1'b1;
            jump_target = rs_val;
          end
          6'h09: begin
            take_jump   = 1'b1;
            jump_target = rs_val;
            alu_result  = pc_plus8;
          end
          default: alu_wr = 1'b0;
        endcase
      end
      6'h09: begin alu_wr = 1'b1; alu_dst = rt; alu_result = rs_val + imm_sext; end
      6'h0A: begin alu_wr = 1'b1; alu_dst = rt;
                   alu_result = {31'd0, $signed(rs_val) < $signed(imm_sext)}; end
      6'h0B: begin alu_wr = 1'b1; alu_dst = rt; alu_result = {31'd0, rs_val < imm_sext}; end
      6'h0C: begin alu_wr = 1'b1; alu_dst = rt; alu_result = rs_val & imm_zext; end
      6'h0D: begin alu_wr = 1'b1; alu_dst = rt; alu_result = rs_val | imm_zext; end
      6'h0E: begin alu_wr = 1'b1; alu_dst = rt; alu_result = rs_val ^ imm_zext; end
      6'h0F: begin alu_wr = 1'b1; alu_dst = rt; alu_result = {imm, 16'h0000}; end
      6'h23: is_lw = 1'b1;
      6'h2B: is_sw = 1'b1;
      6'h04: begin take_jump = (rs_val == rt_val); jump_target = branch_dest; end
      6'h05: begin take_jump = (rs_val != rt_val); jump_target = branch_dest; end
      6'h02: begin
        take_jump   = 1'b1;
        jump_target = {pc_plus4[31:28], instr_readdata[25:0], 2'b00};
      end
      6'h03: begin
        take_jump   = 1'b1;
        jump_target = {pc_plus4[31:28], instr_readdata[25:0], 2'b00};
        alu_wr      = 1'b1;
        alu_dst     = 5'd31;
        alu_result  = pc_plus8;
      end
      default: ;
    endcase
  end

  // Sequencing. A taken branch only records its target; the following
  // (delay-slot) instruction runs and then consumes the pending target.
  logic        wr_en, do_read, do_write;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data, seq_pc;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    active_d     = active_q;
    br_pending_d = br_pending_q;
    br_target_d  = br_target_q;
    load_rt_d    = load_rt_q;
    wr_en        = 1'b0;
    wr_addr      = '0;
    wr_data      = '0;
    do_read      = 1'b0;
    do_write     = 1'b0;
    seq_pc       = br_pending_q ? br_target_q : pc_plus4;
    case (state_q)
      S_FETCH: state_d = S_EXEC;
      S_EXEC: begin
        pc_d         = seq_pc;
        br_pending_d = take_jump;
        br_target_d  = take_jump ? jump_target : br_target_q;
        wr_en        = alu_wr;
        wr_addr      = alu_dst;
        wr_data      = alu_result;
        if (is_lw) begin
          do_read   = 1'b1;
          load_rt_d = rt;
          state_d   = S_MEM;
        end else begin
          do_write = is_sw;
          state_d  = (seq_pc == 32'd0) ? S_HALT : S_FETCH;
        end
      end
      S_MEM: begin
        wr_en   = 1'b1;
        wr_addr = load_rt_q;
        wr_data = data_readdata;
        state_d = (pc_q == 32'd0) ? S_HALT : S_FETCH;
      end
      default: state_d = S_HALT;
    endcase
    if (state_d == S_HALT) active_d = 1'b0;
  end

  always_comb begin
    gpr_d = gpr_q;
    if (wr_en && (wr_addr != 5'd0)) gpr_d[wr_addr] = wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_FETCH;
      pc_q         <= 32'hBFC0_0000;
      active_q     <= 1'b1;
      br_pending_q <= 1'b0;
      br_target_q  <= '0;
      load_rt_q    <= '0;
      for (int i = 0; i < 32; i++) gpr_q[i] <= '0;
    end else if (clk_enable) begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      active_q     <= active_d;
      br_pending_q <= br_pending_d;
      br_target_q  <= br_target_d;
      load_rt_q    <= load_rt_d;
      gpr_q        <= gpr_d;
    end
  end

  // Strobes are gated by clk_enable so a frozen EXEC cycle cannot touch RAM.
  assign data_read      = (state_q == S_EXEC) && do_read && clk_enable;
  assign data_write     = (state_q == S_EXEC) && do_write && clk_enable;
  assign data_address   = rs_val + imm_sext;
  assign data_writedata = rt_val;
  assign instr_address  = pc_q;
  assign active         = active_q;
  assign register_v0    = gpr_q[2];
  assign check_state    = state_q;
  assign check_pcout    = pc_q;

endmodule

// File: tb/tb_mips_harvard_cpu.sv
module tb_mips_harvard_cpu;

  logic        clk;
  logic        reset;
  logic        clk_enable;
  logic        active;
  logic [31:0] register_v0;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic [31:0] data_address;
  logic        data_write;
  logic        data_read;
  logic [31:0] data_writedata;
  logic [31:0] data_readdata;
  logic [1:0]  check_state;
  logic [31:0] check_pcout;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } store_t;

  store_t      expStores[$];
  int          vectorCount = 0;
  int          missCount   = 0;
  int          loadCount   = 0;
  int          loadIdx     = 0;
  logic [31:0] rom [64];
  logic [31:0] ram [256];

  mips_harvard_cpu dut (
    .clk            (clk),
    .reset          (reset),
    .active         (active),
    .register_v0    (register_v0),
    .clk_enable     (clk_enable),
    .instr_address  (instr_address),
    .instr_readdata (instr_readdata),
    .data_address   (data_address),
    .data_write     (data_write),
    .data_read      (data_read),
    .data_writedata (data_writedata),
    .data_readdata  (data_readdata),
    .check_state    (check_state),
    .check_pcout    (check_pcout)
  );

  // Free-running clock, 10 time units per cycle
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read instruction ROM and data RAM
  always @(posedge clk) begin
    instr_readdata <= rom[instr_address[7:2]];
    if (data_write) ram[data_address[9:2]] <= data_writedata;
    if (data_read) data_readdata <= ram[data_address[9:2]];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  // Store scoreboard: each store seen on the bus retires the oldest expectation
  always @(negedge clk) begin
    store_t s;
    if (data_write) begin
      if (expStores.size() == 0) begin
        checkOutput("store_extra", data_address, 32'hFFFF_FFFF);
      end else begin
        s = expStores.pop_front();
        checkOutput("store_addr", data_address, s.addr);
        checkOutput("store_data", data_writedata, s.data);
      end
    end
    if (data_read) loadCount++;
  end

  function automatic logic [31:0] encR(input int rs, input int rt, input int rd,
                                       input int sh, input int fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction

  function automatic logic [31:0] encI(input int op, input int rs, input int rt,
                                       input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] encJ(input int op, input int idx);
    logic [31:0] target;
    target = RESET_PC + 32'(idx * 4);
    return {6'(op), target[27:2]};
  endfunction

  task automatic put(input logic [31:0] word);
    rom[loadIdx] = word;
    loadIdx++;
  endtask

  task automatic pushStore(input logic [31:0] addr, input logic [31:0] data);
    store_t s;
    s.addr = addr;
    s.data = data;
    expStores.push_back(s);
  endtask

  // Runs until halt, counting enabled edges; optionally freezes for 5 edges
  task automatic runProgram(input int freezeAt, output int cycles);
    int guard;
    logic [31:0] pcHold, v0Hold;
    logic [1:0]  stHold;
    cycles = 0;
    guard  = 0;
    while (active && guard < 2000) begin
      if (cycles == freezeAt) begin
        pcHold = check_pcout;
        v0Hold = register_v0;
        stHold = check_state;
        clk_enable = 1'b0;
        #1;
        checkOutput("freeze_strobes", {30'd0, data_read, data_write}, 32'd0);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("freeze_pc", check_pcout, pcHold);
        checkOutput("freeze_v0", register_v0, v0Hold);
        checkOutput("freeze_state", {30'd0, check_state}, {30'd0, stHold});
        clk_enable = 1'b1;
      end
      @(posedge clk);
      #1;
      cycles++;
      guard++;
    end
    checkOutput("active_after_run", {31'd0, active}, 32'd0);
  endtask

  task automatic applyStimulus(input int prog);
    logic [31:0] expV0;
    int expCycles, freezeAt, expLoads, cycles;
    for (int i = 0; i < 64; i++) rom[i] = 32'd0;
    loadIdx  = 0;
    expStores.delete();
    freezeAt = -1;
    expLoads = 0;
    expV0    = 32'd0;
    expCycles = 0;
    case (prog)
      1: begin
        put(encI(6'h09, 0, 2, 5));
        put(encR(0, 0, 0, 0, 6'h08));
        put(32'd0);
        expV0 = 32'd5; expCycles = 6;
      end
      2: begin
        put(encI(6'h09, 0, 4, 16));
        put(encI(6'h0F, 0, 3, 16'h1234));
        put(encI(6'h0D, 3, 3, 16'h5678));
        put(encI(6'h2B, 4, 3, 0));
        put(encI(6'h23, 4, 2, 0));
        put(encR(0, 0, 0, 0, 6'h08));
        put(32'd0);
        pushStore(32'h10, 32'h1234_5678);
        expV0 = 32'h1234_5678; expCycles = 15; expLoads = 1; freezeAt = 9;
      end
      3: begin
        put(encI(6'h09, 0, 5, -3));
        put(encI(6'h09, 0, 6, 7));
        put(encR(5, 6, 7, 0, 6'h21)); put(encI(6'h2B, 0, 7, 16'h20));
        put(encR(5, 6, 7, 0, 6'h23)); put(encI(6'h2B, 0, 7, 16'h24));
        put(encR(5, 6, 7, 0, 6'h2A)); put(encI(6'h2B, 0, 7, 16'h28));
        put(encR(5, 6, 7, 0, 6'h2B)); put(encI(6'h2B, 0, 7, 16'h2C));
        put(encR(0, 6, 7, 4, 6'h00)); put(encI(6'h2B, 0, 7, 16'h30));
        put(encR(0, 5, 7, 28, 6'h02)); put(encI(6'h2B, 0, 7, 16'h34));
        put(encR(0, 5, 7, 1, 6'h03)); put(encI(6'h2B, 0, 7, 16'h38));
        put(encR(5, 6, 7, 0, 6'h24)); put(encI(6'h2B, 0, 7, 16'h3C));
        put(encR(5, 6, 7, 0, 6'h25)); put(encI(6'h2B, 0, 7, 16'h40));
        put(encR(5, 6, 7, 0, 6'h26)); put(encI(6'h2B, 0, 7, 16'h44));
        put(encI(6'h0C, 5, 7, 16'hFFF0)); put(encI(6'h2B, 0, 7, 16'h48));
        put(encI(6'h0E, 5, 7, 16'h8000)); put(encI(6'h2B, 0, 7, 16'h4C));
        put(encI(6'h0A, 5, 7, -2)); put(encI(6'h2B, 0, 7, 16'h50));
        put(encI(6'h0B, 6, 7, -1)); put(encI(6'h2B, 0, 7, 16'h54));
        put(encI(6'h09, 0, 0, 9)); put(encI(6'h2B, 0, 0, 16'h58));
        put(encI(6'h09, 0, 8, 16'h100)); put(encI(6'h2B, 8, 6, -4));
        put(encR(0, 0, 0, 0, 6'h08));
        put(32'd0);
        pushStore(32'h20, 32'h0000_0004);
        pushStore(32'h24, 32'hFFFF_FFF6);
        pushStore(32'h28, 32'h0000_0001);
        pushStore(32'h2C, 32'h0000_0000);
        pushStore(32'h30, 32'h0000_0070);
        pushStore(32'h34, 32'h0000_000F);
        pushStore(32'h38, 32'hFFFF_FFFE);
        pushStore(32'h3C, 32'h0000_0005);
        pushStore(32'h40, 32'hFFFF_FFFF);
        pushStore(32'h44, 32'hFFFF_FFFA);
        pushStore(32'h48, 32'h0000_FFF0);
        pushStore(32'h4C, 32'hFFFF_7FFD);
        pushStore(32'h50, 32'h0000_0001);
        pushStore(32'h54, 32'h0000_0001);
        pushStore(32'h58, 32'h0000_0000);
        pushStore(32'hFC, 32'h0000_0007);
        expV0 = 32'd0; expCycles = 72;
      end
      4: begin
        put(encI(6'h09, 0, 2, 0));
        put(encI(6'h04, 0, 0, 2));
        put(encI(6'h09, 2, 2, 1));
        put(encI(6'h09, 2, 2, 16));
        put(encI(6'h2B, 0, 2, 16'h80));
        put(encI(6'h05, 2, 0, 1));
        put(encI(6'h09, 2, 2, 2));
        put(encI(6'h05, 0, 0, 5));
        put(encI(6'h2B, 0, 2, 16'h84));
        put(encR(0, 0, 0, 0, 6'h08));
        put(32'd0);
        pushStore(32'h80, 32'd1);
        pushStore(32'h84, 32'd3);
        expV0 = 32'd3; expCycles = 20;
      end
      default: begin
        put(encI(6'h09, 0, 2, 1));
        put(encJ(6'h03, 8));
        put(encI(6'h09, 2, 2, 1));
        put(encR(31, 0, 2, 0, 6'h21));
        put(encI(6'h2B, 0, 2, 16'h90));
        put(encJ(6'h02, 11));
        put(32'd0);
        put(encI(6'h09, 0, 2, 16'h77));
        put(encI(6'h2B, 0, 2, 16'h8C));
        put(encR(31, 0, 0, 0, 6'h08));
        put(32'd0);
        put(encI(6'h09, 0, 10, 0));
        put(encR(10, 0, 2, 0, 6'h09));
        put(32'd0);
        pushStore(32'h8C, 32'd2);
        pushStore(32'h90, 32'hBFC0_000C);
        expV0 = 32'hBFC0_0038; expCycles = 26; freezeAt = 7;
      end
    endcase

    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    loadCount = 0;
    checkOutput("rst_state", {30'd0, check_state}, 32'd0);
    checkOutput("rst_pc", check_pcout, RESET_PC);
    checkOutput("rst_active", {31'd0, active}, 32'd1);
    checkOutput("rst_v0", register_v0, 32'd0);

    // Abort the first instruction mid-EXEC: its GPR write must not land
    if (prog == 1) begin
      @(posedge clk);
      #1;
      checkOutput("mid_exec_state", {30'd0, check_state}, 32'd1);
      reset = 1'b0;
      #1;
      checkOutput("mid_rst_v0", register_v0, 32'd0);
      checkOutput("mid_rst_state", {30'd0, check_state}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;
    end

    runProgram(freezeAt, cycles);
    checkOutput($sformatf("p%0d_cycles", prog), 32'(cycles), 32'(expCycles));
    checkOutput($sformatf("p%0d_v0", prog), register_v0, expV0);
    checkOutput($sformatf("p%0d_halt_state", prog), {30'd0, check_state}, 32'd3);
    checkOutput($sformatf("p%0d_halt_pc", prog), check_pcout, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput($sformatf("p%0d_stay_halted", prog), {29'd0, active, check_state}, 32'd3);
    checkOutput($sformatf("p%0d_stores_left", prog), 32'(expStores.size()), 32'd0);
    checkOutput($sformatf("p%0d_loads", prog), 32'(loadCount), 32'(expLoads));
  endtask

  initial begin
    reset      = 1'b0;
    clk_enable = 1'b1;
    for (int i = 0; i < 64; i++) rom[i] = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("in_rst_state", {30'd0, check_state}, 32'd0);
    checkOutput("in_rst_pc", check_pcout, RESET_PC);
    checkOutput("in_rst_strobes", {30'd0, data_read, data_write}, 32'd0);
    for (int p = 1; p <= 5; p++) begin
      $display("[TB] program %0d", p);
      applyStimulus(p);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
